k_and_s_control_unit: RTL

Multi-cycle control FSM for the K&S processor, sitting directly beside the datapath. It consumes the datapath's decoded instruction and flag outputs and drives every datapath control strobe plus the RAM write enable. It sequences fetch, decode and execute for LOAD, STORE, MOVE, ADD, SUB, AND, OR, BRANCH, conditional branches, NOP and HALT. It also keeps a retired-instruction counter for verification.

---
 rtl/k_and_s_pkg.sv | 31 +++
 rtl/k_and_s_branch_cond.sv | 30 +++
 rtl/k_and_s_control_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// Shared K&S types: instruction decode, control FSM states and ALU opcodes.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        S_FETCH, S_FETCH_WAIT, S_DECODE, S_LOAD_ADDR, S_LOAD_WB,
        S_STORE, S_MOVE, S_ALU, S_BRANCH, S_HALT
    } ctrl_state_type;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    function automatic logic [1:0] alu_op_of(decoded_instruction_type instr);
        logic [1:0] op;
        op = ALU_ADD;
        case (instr)
            I_AND:   op = ALU_AND;
            I_OR:    op = ALU_OR;
            I_SUB:   op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/k_and_s_branch_cond.sv
// Evaluates conditional-branch predicates against the registered datapath flags.
module k_and_s_branch_cond
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    take_branch
);

    // Carried in the interface for future unsigned branches.
    logic unused_unsigned_overflow;
    assign unused_unsigned_overflow = unsigned_overflow;

    always_comb begin
        take_branch = 1'b0;
        case (decoded_instruction)
            I_BZERO:  take_branch = zero_op;
            I_BNZERO: take_branch = ~zero_op;
            I_BNEG:   take_branch = neg_op;
            I_BNNEG:  take_branch = ~neg_op;
            I_BOV:    take_branch = signed_overflow;
            I_BNOV:   take_branch = ~signed_overflow;
            default:  take_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/k_and_s_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the K&S datapath, with a
// retired-instruction counter.
module k_and_s_control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halted,
    output logic [CNT_W-1:0]        instr_retired
);

    ctrl_state_type   state_q, state_d;
    logic [CNT_W-1:0] instr_retired_q;
    logic             take_branch;
    logic             retire;

    k_and_s_branch_cond u_branch_cond (
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .take_branch         (take_branch)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:                    state_d = S_LOAD_ADDR;
                    I_STORE:                   state_d = S_STORE;
                    I_MOVE:                    state_d = S_MOVE;
                    I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU;
                    I_BRANCH:                  state_d = S_BRANCH;
                    I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                        state_d = take_branch ? S_BRANCH : S_FETCH;
                    I_HALT:                    state_d = S_HALT;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_LOAD_ADDR:  state_d = S_LOAD_WB;
            S_LOAD_WB, S_STORE, S_MOVE, S_ALU, S_BRANCH: state_d = S_FETCH;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge leaving its last state; HALT retires
    // entering S_HALT and the counter is frozen thereafter.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE: retire = (state_d == S_FETCH) || (state_d == S_HALT);
            S_LOAD_WB, S_STORE, S_MOVE, S_ALU, S_BRANCH: retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = ALU_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halted           = 1'b0;
        case (state_q)
            S_FETCH_WAIT: ir_enable = 1'b1;
            S_DECODE:     pc_enable = 1'b1;
            S_LOAD_ADDR:  addr_sel  = 1'b1;
            S_LOAD_WB: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
            end
            S_STORE: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
            end
            // MOVE passes the source through as src AND src, leaving flags alone.
            S_MOVE: begin
                operation        = ALU_AND;
                write_reg_enable = 1'b1;
            end
            S_ALU: begin
                operation        = alu_op_of(decoded_instruction);
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
            end
            S_BRANCH: begin
                pc_enable = 1'b1;
                branch    = 1'b1;
            end
            S_HALT:       halted = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_FETCH;
            instr_retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_retired_q <= instr_retired_q + CNT_W'(1);
            end
        end
    end

    assign instr_retired = instr_retired_q;

endmodule
